// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: bubble encoding, base opcodes and the fetch FSM state type.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_FETCH = 2'd1,
        F_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between two stages: flush beats stall, stall beats load,
// and an idle cycle inserts a bubble.
module if_id_reg #(
    parameter int          XLEN   = 32,
    parameter logic [31:0] BUBBLE = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [31:0]     load_instr,
    input  logic [XLEN-1:0] load_pc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid
);
    import riscv_pkg::*;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= BUBBLE;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= BUBBLE;
            pc       <= '0;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                instr    <= load_instr;
                pc       <= load_pc;
                pc_plus4 <= load_pc + XLEN'(4);
                valid    <= 1'b1;
            end else begin
                instr    <= BUBBLE;
                pc       <= '0;
                pc_plus4 <= '0;
                valid    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, req/ack imem handshake with wait states,
// one-entry skid buffer for stalled Decode, and the Fetch-Decode register.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            iclk,
    input  logic            irst_n,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemAck,
    input  logic [31:0]     ImemRdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic [6:0]      opD,
    output logic [2:0]      funct3D,
    output logic            funct7b5D
);
    import riscv_pkg::*;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc_f, pc_next;
    logic [XLEN-1:0] req_addr, req_next;
    logic            discard_pending, disc_next;
    logic [31:0]     buf_instr;
    logic [XLEN-1:0] buf_pc;
    logic            buf_load;
    logic            deliver;
    logic [31:0]     deliver_instr;
    logic [XLEN-1:0] deliver_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] req_plus4;

    assign target    = PCTargetE & ~XLEN'(3);
    assign req_plus4 = req_addr + XLEN'(4);   // wraps modulo 2^XLEN

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) state <= F_IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc_f;
        req_next      = req_addr;
        disc_next     = discard_pending;
        buf_load      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = buf_instr;
        deliver_pc    = buf_pc;
        ImemReq       = 1'b0;
        case (state)
            F_IDLE: begin
                // ImemAck is deliberately not sampled here: a response left over
                // from before reset must not be taken as ours.
                state_next = F_FETCH;
                if (PCSrcE) begin
                    pc_next  = target;
                    req_next = target;
                end
            end
            F_FETCH: begin
                ImemReq = 1'b1;
                if (PCSrcE) begin
                    pc_next = target;
                    if (ImemAck) begin
                        req_next  = target;
                        disc_next = 1'b0;
                    end else begin
                        // request stays up; its data is wrong-path and gets dropped
                        disc_next = 1'b1;
                    end
                end else if (ImemAck) begin
                    if (discard_pending) begin
                        req_next  = pc_f;
                        disc_next = 1'b0;
                    end else begin
                        pc_next  = req_plus4;
                        req_next = req_plus4;
                        if (StallD) begin
                            buf_load   = 1'b1;
                            state_next = F_HOLD;
                        end else begin
                            deliver       = 1'b1;
                            deliver_instr = ImemRdata;
                            deliver_pc    = req_addr;
                        end
                    end
                end
            end
            F_HOLD: begin
                if (PCSrcE) begin
                    pc_next    = target;
                    req_next   = target;
                    state_next = F_FETCH;
                end else if (!StallD) begin
                    deliver    = 1'b1;
                    req_next   = pc_f;
                    state_next = F_FETCH;
                end
            end
            default: state_next = F_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            pc_f            <= RESET_PC;
            req_addr        <= RESET_PC;
            discard_pending <= 1'b0;
            buf_instr       <= NOP_INSTR;
            buf_pc          <= '0;
        end else begin
            pc_f            <= pc_next;
            req_addr        <= req_next;
            discard_pending <= disc_next;
            if (buf_load) begin
                buf_instr <= ImemRdata;
                buf_pc    <= req_addr;
            end
        end
    end

    assign ImemAddr = req_addr;

    if_id_reg #(
        .XLEN   (XLEN),
        .BUBBLE (NOP_INSTR)
    ) u_if_id (
        .clk        (iclk),
        .rst_n      (irst_n),
        .flush      (FlushD),
        .stall      (StallD),
        .load       (deliver),
        .load_instr (deliver_instr),
        .load_pc    (deliver_pc),
        .instr      (InstrD),
        .pc         (PCD),
        .pc_plus4   (PCPlus4D),
        .valid      (ValidD)
    );

    assign opD       = InstrD[6:0];
    assign funct3D   = InstrD[14:12];
    assign funct7b5D = InstrD[30];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a wait-state imem model pushes expected
// Decode contents on each right-path ack; Decode outputs are popped and compared.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b1;
    logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0, ImemAck = 1'b0;
    logic [31:0] PCTargetE = '0, ImemRdata = '0;
    logic        ImemReq, ValidD, funct7b5D;
    logic [31:0] ImemAddr, InstrD, PCD, PCPlus4D;
    logic [6:0]  opD;
    logic [2:0]  funct3D;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .iclk(iclk), .irst_n(irst_n), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemAck(ImemAck), .ImemRdata(ImemRdata), .InstrD(InstrD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .ValidD(ValidD), .opD(opD), .funct3D(funct3D),
        .funct7b5D(funct7b5D)
    );

    always #5 iclk = ~iclk;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int wait_n = 0, wcnt = 0;
    bit tb_disc = 0, prev_stall = 0, prev_flush = 0;
    logic [31:0] last_instr = NOP, last_pc = '0, last_p4 = '0;
    logic        last_valid = 1'b0;

    // I-type ALU words whose immediate and funct3 follow the address
    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[11:0], 5'd0, a[4:2], 5'd1, 7'h13};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_decode();
        exp_t e;
        if (prev_flush) begin
            chk("flush_instr", InstrD, NOP);
            chk("flush_valid", 32'(ValidD), 32'd0);
            chk("flush_pc", PCD, 32'd0);
        end else if (prev_stall) begin
            chk("stall_instr", InstrD, last_instr);
            chk("stall_pc", PCD, last_pc);
            chk("stall_pc4", PCPlus4D, last_p4);
            chk("stall_valid", 32'(ValidD), 32'(last_valid));
        end else if (ValidD) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_valid", 32'(ValidD), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("dec_instr", InstrD, e.instr);
                chk("dec_pc", PCD, e.pc);
                chk("dec_pc4", PCPlus4D, e.pc + 32'd4);
                chk("dec_op", 32'(opD), 32'(e.instr[6:0]));
                chk("dec_f3", 32'(funct3D), 32'(e.instr[14:12]));
                chk("dec_f7b5", 32'(funct7b5D), 32'(e.instr[30]));
            end
        end else begin
            chk("bubble_instr", InstrD, NOP);
            chk("bubble_pc", PCD, 32'd0);
            chk("bubble_pc4", PCPlus4D, 32'd0);
        end
        last_instr = InstrD; last_pc = PCD; last_p4 = PCPlus4D; last_valid = ValidD;
    endtask

    // one clock: imem model answers the current request, then sample after the edge
    task automatic step();
        if (ImemReq) begin
            if (wcnt >= wait_n) begin
                ImemAck = 1'b1; ImemRdata = word(ImemAddr); wcnt = 0;
            end else begin
                ImemAck = 1'b0; ImemRdata = 32'hdead_beef; wcnt++;
            end
        end else begin
            ImemAck = 1'b0; wcnt = 0;
        end
        if (ImemAck) begin
            if (tb_disc || PCSrcE) tb_disc = 0;
            else sb.push_back('{word(ImemAddr), ImemAddr});
        end else if (ImemReq && PCSrcE) begin
            tb_disc = 1;
        end
        prev_stall = StallD;
        prev_flush = FlushD;
        @(posedge iclk);
        #1;
        ImemAck = 1'b0;
        check_decode();
    endtask

    task automatic reset_checks(input string pfx);
        chk({pfx, "_req"}, 32'(ImemReq), 32'd0);
        chk({pfx, "_instr"}, InstrD, NOP);
        chk({pfx, "_valid"}, 32'(ValidD), 32'd0);
        chk({pfx, "_pc"}, PCD, 32'd0);
        chk({pfx, "_pc4"}, PCPlus4D, 32'd0);
        chk({pfx, "_op"}, 32'(opD), 32'h13);
        chk({pfx, "_f3"}, 32'(funct3D), 32'd0);
        chk({pfx, "_f7b5"}, 32'(funct7b5D), 32'd0);
    endtask

    task automatic sync_bench_state();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        tb_disc = 0; wcnt = 0; prev_stall = 0; prev_flush = 0;
        last_instr = NOP; last_pc = '0; last_p4 = '0; last_valid = 1'b0;
    endtask

    task automatic do_reset();
        irst_n = 1'b0; StallD = 0; FlushD = 0; PCSrcE = 0; ImemAck = 0;
        #1;
        reset_checks("rst");
        sync_bench_state();
        repeat (2) @(posedge iclk);
        #1;
        irst_n = 1'b1;
        chk("rel_idle_req", 32'(ImemReq), 32'd0);
        step();
        chk("rel_req", 32'(ImemReq), 32'd1);
        chk("rel_addr", ImemAddr, 32'h0);
    endtask

    initial begin
        #2;
        // zero-wait stream, then a 3-cycle stall landing on the ack of 0x8
        wait_n = 0;
        do_reset();
        step();
        chk("zw_addr4", ImemAddr, 32'h4);
        chk("zw_valid0", 32'(ValidD), 32'd1);
        chk("zw_op", 32'(opD), 32'h13);
        step();
        chk("zw_addr8", ImemAddr, 32'h8);
        StallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_req", 32'(ImemReq), 32'd0);
        end
        StallD = 1'b0;
        step();
        chk("resume_pc", PCD, 32'h8);
        chk("resume_req", 32'(ImemReq), 32'd1);
        chk("resume_addr", ImemAddr, 32'hC);

        // redirect to 0x100 while 0x10 waits
        step();
        chk("addr10", ImemAddr, 32'h10);
        wait_n = 2;
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        chk("redir_req_kept", ImemAddr, 32'h10);
        step();
        chk("redir_addr", ImemAddr, 32'h100);
        chk("redir_drop", 32'(ValidD), 32'd0);
        repeat (3) step();
        chk("redir_pc", PCD, 32'h100);
        chk("redir_valid", 32'(ValidD), 32'd1);

        // two wait states from reset
        do_reset();
        step();
        chk("w_addr1", ImemAddr, 32'h0);
        chk("w_bub1", 32'(ValidD), 32'd0);
        step();
        chk("w_addr2", ImemAddr, 32'h0);
        chk("w_bub2", 32'(ValidD), 32'd0);
        step();
        chk("w_valid", 32'(ValidD), 32'd1);
        chk("w_pc", PCD, 32'h0);
        chk("w_pc4", PCPlus4D, 32'h4);

        // flush wins over stall
        FlushD = 1'b1; StallD = 1'b1;
        step();
        FlushD = 1'b0; StallD = 1'b0;
        chk("fs_instr", InstrD, NOP);
        chk("fs_valid", 32'(ValidD), 32'd0);

        // unaligned target is masked
        PCSrcE = 1'b1; PCTargetE = 32'h203;
        step();
        PCSrcE = 1'b0;
        step();
        chk("mask_addr", ImemAddr, 32'h200);
        repeat (3) step();
        chk("mask_pc", PCD, 32'h200);

        // redirect coinciding with the ack
        wait_n = 0;
        PCSrcE = 1'b1; PCTargetE = 32'h300;
        step();
        PCSrcE = 1'b0;
        chk("sameack_addr", ImemAddr, 32'h300);
        chk("sameack_drop", 32'(ValidD), 32'd0);
        repeat (2) step();

        // address wrap
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        step();
        PCSrcE = 1'b0;
        chk("wrap_target", ImemAddr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", ImemAddr, 32'h0);
        chk("wrap_pc4", PCPlus4D, 32'h0);

        // async reset mid-wait; stale ack during IDLE must be ignored
        wait_n = 3;
        #2 irst_n = 1'b0;
        #1;
        reset_checks("mr");
        sync_bench_state();
        ImemAck = 1'b1; ImemRdata = 32'h0000_006f;
        @(posedge iclk);
        #1;
        irst_n = 1'b1;
        chk("mr_idle_req", 32'(ImemReq), 32'd0);
        @(posedge iclk);
        #1;
        ImemAck = 1'b0;
        chk("mr_req", 32'(ImemReq), 32'd1);
        chk("mr_addr", ImemAddr, 32'h0);
        chk("mr_stale_drop", 32'(ValidD), 32'd0);
        wait_n = 0;
        repeat (4) step();
        chk("mr_restart_pc", PCD, 32'hC);
        chk("sb_final", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
